food_rom_arbiter: RTL and testbench

- Shares one synchronous sprite ROM read port (1-cycle registered read latency, 12-bit RGB words) among NUM_REQ pixel/collision requesters in the VGA game datapath.
- Round-robin arbitration, one grant per clock, fully pipelined.
- Returns each ROM word to its owner with a one-hot valid, a fixed 2 cycles after the grant.

---
 rtl/food_rom_arbiter_if.sv | 30 +++
 rtl/food_rom_arbiter.sv | 129 ++++++++++++
 tb/tb_food_rom_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/food_rom_arbiter_if.sv
// Requester-side bundle for food_rom_arbiter: request/address in, grant and
// one-hot tagged ROM response out. "master" is the requester pool, "slave"
// is the arbiter.
interface food_rom_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 12
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;

    modport master (
        output req,
        output req_addr,
        input  gnt,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req,
        input  req_addr,
        output gnt,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/food_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read sprite ROM port among
// NUM_REQ requesters. One grant per clock; the ROM word returns to its owner
// with a one-hot valid exactly two cycles after the grant.
// Optional contention counter enabled by `define FOOD_ROM_ARB_CONFLICT_CNT_EN;
// without it o_conflict_cnt is tied to zero.
module food_rom_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 12
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    food_rom_arbiter_if.slave      req_bus,
    output logic [ADDR_WIDTH-1:0]  o_rom_addr,
    input  logic [DATA_WIDTH-1:0]  i_rom_data,
    output logic [15:0]            o_conflict_cnt
);

    localparam int unsigned TAG_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TAG_WIDTH-1:0] LAST_IDX  = TAG_WIDTH'(NUM_REQ - 1);
    // One extra bit so ptr + offset (< 2*NUM_REQ) cannot overflow before the wrap.
    localparam logic [TAG_WIDTH:0]   NUM_REQ_W = (TAG_WIDTH + 1)'(NUM_REQ);

    logic [TAG_WIDTH-1:0]  r_rr_ptr;
    logic [TAG_WIDTH-1:0]  w_rr_ptr_next;
    logic [TAG_WIDTH-1:0]  w_win;
    logic                  w_any;
    logic [NUM_REQ-1:0]    w_gnt;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic                  r_s1_valid;
    logic [TAG_WIDTH-1:0]  r_s1_tag;
    logic                  r_s2_valid;
    logic [TAG_WIDTH-1:0]  r_s2_tag;
    logic [NUM_REQ-1:0]    w_rsp_valid;

    // Round-robin search starting at r_rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [TAG_WIDTH:0]   v_sum;
        logic [TAG_WIDTH-1:0] v_idx;
        w_any = 1'b0;
        w_win = '0;
        v_sum = '0;
        v_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (TAG_WIDTH + 1)'(k);
            if (v_sum >= NUM_REQ_W) begin
                v_sum = v_sum - NUM_REQ_W;
            end
            v_idx = v_sum[TAG_WIDTH-1:0];
            if (!w_any && req_bus.req[v_idx]) begin
                w_any = 1'b1;
                w_win = v_idx;
            end
        end
        // Reset suppresses any grant, including a req rising in the same cycle.
        if (i_reset) begin
            w_any = 1'b0;
            w_win = '0;
        end
    end

    // Grant vector, winning address and next pointer derived from the winner.
    always_comb begin
        w_gnt         = w_any ? (NUM_REQ'(1) << w_win) : '0;
        w_win_addr    = req_bus.req_addr[32'(w_win) * ADDR_WIDTH +: ADDR_WIDTH];
        w_rr_ptr_next = r_rr_ptr;
        if (w_any) begin
            w_rr_ptr_next = (w_win == LAST_IDX) ? '0 : w_win + TAG_WIDTH'(1);
        end
    end

    // Pointer, ROM address and the two-stage valid/tag pipeline.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr   <= '0;
            r_rom_addr <= '0;
            r_s1_valid <= 1'b0;
            r_s1_tag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_tag   <= '0;
        end else begin
            r_rr_ptr <= w_rr_ptr_next;
            // With no grant the ROM keeps reading the last address; only the valid clears.
            if (w_any) begin
                r_rom_addr <= w_win_addr;
            end
            r_s1_valid <= w_any;
            r_s1_tag   <= w_win;
            r_s2_valid <= r_s1_valid;
            r_s2_tag   <= r_s1_tag;
        end
    end

    // Decode the stage-2 tag into the owner's one-hot response valid.
    always_comb begin
        w_rsp_valid = '0;
        if (r_s2_valid) begin
            w_rsp_valid = NUM_REQ'(1) << r_s2_tag;
        end
    end

    assign req_bus.gnt       = w_gnt;
    assign req_bus.rsp_valid = w_rsp_valid;
    assign req_bus.rsp_data  = i_rom_data;
    assign o_rom_addr        = r_rom_addr;

`ifdef FOOD_ROM_ARB_CONFLICT_CNT_EN
    logic [15:0] r_conflict_cnt;
    logic        w_contention;

    // Two or more requesters means somebody is denied this cycle.
    assign w_contention = |(req_bus.req & (req_bus.req - NUM_REQ'(1)));

    // Saturating count of contended cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_conflict_cnt <= 16'h0000;
        end else if (w_contention && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign o_conflict_cnt = r_conflict_cnt;
`else
    assign o_conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_food_rom_arbiter.sv
// Self-checking bench for food_rom_arbiter (NUM_REQ=4). ROM[k] = k + 12'h100,
// registered read. Directed scenarios plus a randomized run against a
// queue-based reference model. Saturation scenario runs only with
// FOOD_ROM_ARB_CONFLICT_CNT_EN defined.
module tb_food_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 20;
    localparam int DW = 12;

    logic          clk;
    logic          reset;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [15:0]   conflict_cnt;

    food_rom_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    food_rom_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .req_bus        (bus),
        .o_rom_addr     (rom_addr),
        .i_rom_data     (rom_data),
        .o_conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite ROM model: registered read.
    always @(posedge clk) rom_data <= rom_addr[11:0] + 12'h100;

    int checks = 0;
    int errors = 0;

    // Reference model state
    typedef struct {
        int          due;
        int          owner;
        logic [19:0] addr;
    } rsp_t;
    rsp_t        pend[$];
    int          cyc    = 0;
    int          m_ptr  = 0;
    logic [19:0] m_rom  = '0;
    int          m_conf = 0;

    logic [3:0]  cur_req;
    logic [79:0] cur_addr;
    logic        cur_rst;

    int          exp_win;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_rv;
    logic [11:0] exp_rd;
    logic [19:0] exp_rom;
    logic [15:0] exp_cnt;

    function automatic logic [79:0] pack(input logic [19:0] a0, input logic [19:0] a1,
                                         input logic [19:0] a2, input logic [19:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Drive one cycle of inputs, then at the falling edge compute what the DUT should show.
    task automatic tick(input logic [3:0] r, input logic [79:0] a, input logic rst);
        bus.req      = r;
        bus.req_addr = a;
        reset        = rst;
        cur_req      = r;
        cur_addr     = a;
        cur_rst      = rst;
        @(negedge clk);
        exp_win = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                if (exp_win < 0 && r[(m_ptr + k) % N]) exp_win = (m_ptr + k) % N;
            end
        end
        exp_gnt = (exp_win >= 0) ? 4'(1 << exp_win) : 4'b0000;
        exp_rv  = 4'b0000;
        exp_rd  = 12'h000;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_rv = 4'(1 << pend[0].owner);
            exp_rd = pend[0].addr[11:0] + 12'h100;
            void'(pend.pop_front());
        end
        exp_rom = m_rom;
`ifdef FOOD_ROM_ARB_CONFLICT_CNT_EN
        exp_cnt = 16'(m_conf);
`else
        exp_cnt = 16'h0000;
`endif
    endtask

    // Advance the model across the rising edge and move to just after it.
    task automatic tock();
        rsp_t e;
        if (cur_rst) begin
            pend.delete();
            m_ptr  = 0;
            m_rom  = '0;
            m_conf = 0;
        end else begin
            if (exp_win >= 0) begin
                e.due   = cyc + 2;
                e.owner = exp_win;
                e.addr  = cur_addr[exp_win*20 +: 20];
                pend.push_back(e);
                m_ptr = (exp_win + 1) % N;
                m_rom = e.addr;
            end
            if ($countones(cur_req) >= 2 && m_conf < 65535) m_conf++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        tick(4'b1111, pack(1, 2, 3, 4), 1'b1);
        checks++;
        if (bus.gnt !== 4'b0000) begin
            errors++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt);
        end
        tock();
        tick(4'b1111, pack(1, 2, 3, 4), 1'b1);
        checks++;
        if (bus.gnt !== 4'b0000) begin
            errors++; $display("FAIL reset_gnt2: got %b expected 0000", bus.gnt);
        end
        checks++;
        if (bus.rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid);
        end
        checks++;
        if (rom_addr !== 20'h0) begin
            errors++; $display("FAIL reset_rom_addr: got %h expected 0", rom_addr);
        end
        checks++;
        if (conflict_cnt !== 16'h0) begin
            errors++; $display("FAIL reset_conflict: got %h expected 0", conflict_cnt);
        end
        tock();
    endtask

    task automatic test_single();
        tick(4'b0100, pack(0, 0, 5, 0), 1'b0);
        checks++;
        if (bus.gnt !== 4'b0100) begin
            errors++; $display("FAIL single_gnt: got %b expected 0100", bus.gnt);
        end
        tock();
        tick(4'b0000, '0, 1'b0);
        checks++;
        if (rom_addr !== 20'd5) begin
            errors++; $display("FAIL single_rom_addr: got %h expected 5", rom_addr);
        end
        tock();
        tick(4'b0000, '0, 1'b0);
        checks++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 12'h105) begin
            errors++;
            $display("FAIL single_rsp: got %b/%h expected 0100/105", bus.rsp_valid, bus.rsp_data);
        end
        tock();
    endtask

    // Pointer sits at 3 after the single grant to requester 2.
    task automatic test_wrap();
        tick(4'b1001, pack(20'h20, 0, 0, 20'h23), 1'b0);
        checks++;
        if (bus.gnt !== 4'b1000) begin
            errors++; $display("FAIL wrap_gnt0: got %b expected 1000", bus.gnt);
        end
        tock();
        tick(4'b1001, pack(20'h20, 0, 0, 20'h23), 1'b0);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++; $display("FAIL wrap_gnt1: got %b expected 0001", bus.gnt);
        end
        tock();
        tick(4'b0000, '0, 1'b0);
        checks++;
        if (bus.rsp_valid !== 4'b1000 || bus.rsp_data !== 12'h123) begin
            errors++;
            $display("FAIL wrap_rsp0: got %b/%h expected 1000/123", bus.rsp_valid, bus.rsp_data);
        end
        tock();
        tick(4'b0000, '0, 1'b0);
        checks++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 12'h120) begin
            errors++;
            $display("FAIL wrap_rsp1: got %b/%h expected 0001/120", bus.rsp_valid, bus.rsp_data);
        end
        tock();
    endtask

    task automatic test_contention();
        logic [3:0]  eg;
        logic [11:0] ed;
        tick(4'b0000, '0, 1'b1);
        tock();
        for (int k = 0; k < 10; k++) begin
            tick((k < 8) ? 4'b1111 : 4'b0000, pack(0, 1, 2, 3), 1'b0);
            if (k < 8) begin
                eg = 4'(1 << (k % 4));
                checks++;
                if (bus.gnt !== eg) begin
                    errors++; $display("FAIL contention_gnt[%0d]: got %b expected %b", k, bus.gnt, eg);
                end
            end
            if (k >= 2) begin
                eg = 4'(1 << ((k - 2) % 4));
                ed = 12'(12'h100 + (k - 2) % 4);
                checks++;
                if (bus.rsp_valid !== eg || bus.rsp_data !== ed) begin
                    errors++;
                    $display("FAIL contention_rsp[%0d]: got %b/%h expected %b/%h",
                             k, bus.rsp_valid, bus.rsp_data, eg, ed);
                end
            end
            if (k == 8) begin
                checks++;
`ifdef FOOD_ROM_ARB_CONFLICT_CNT_EN
                if (conflict_cnt !== 16'd8) begin
                    errors++; $display("FAIL contention_cnt: got %0d expected 8", conflict_cnt);
                end
`else
                if (conflict_cnt !== 16'd0) begin
                    errors++; $display("FAIL contention_cnt: got %0d expected 0", conflict_cnt);
                end
`endif
            end
            tock();
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] ed;
        for (int k = 0; k < 5; k++) begin
            tick((k < 3) ? 4'b0001 : 4'b0000, pack(20'(10 + k), 0, 0, 0), 1'b0);
            checks++;
            if (bus.gnt !== ((k < 3) ? 4'b0001 : 4'b0000)) begin
                errors++; $display("FAIL b2b_gnt[%0d]: got %b", k, bus.gnt);
            end
            if (k >= 2) begin
                ed = 12'(12'h10A + (k - 2));
                checks++;
                if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== ed) begin
                    errors++;
                    $display("FAIL b2b_rsp[%0d]: got %b/%h expected 0001/%h",
                             k, bus.rsp_valid, bus.rsp_data, ed);
                end
            end
            tock();
        end
    endtask

    // Pointer is 1 here; a contended grant bumps the counter before reset clears it.
    task automatic test_reset_midflight();
        tick(4'b0110, pack(0, 20'h33, 20'h44, 0), 1'b0);
        checks++;
        if (bus.gnt !== 4'b0010) begin
            errors++; $display("FAIL midflight_gnt: got %b expected 0010", bus.gnt);
        end
        tock();
        tick(4'b0000, '0, 1'b1);
        tock();
        tick(4'b0000, '0, 1'b0);
        checks++;
        if (bus.rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL midflight_rsp: got %b expected 0000", bus.rsp_valid);
        end
        checks++;
        if (conflict_cnt !== 16'h0) begin
            errors++; $display("FAIL midflight_cnt: got %h expected 0", conflict_cnt);
        end
        tock();
        tick(4'b1111, pack(1, 2, 3, 4), 1'b0);
        checks++;
        if (bus.gnt !== 4'b0001) begin
            errors++; $display("FAIL midflight_ptr: got %b expected 0001", bus.gnt);
        end
        tock();
        tick(4'b0000, '0, 1'b0);
        tock();
        tick(4'b0000, '0, 1'b0);
        tock();
    endtask

    task automatic test_random();
        logic [3:0]  r = '0;
        logic [79:0] a = '0;
        logic        rst;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            tick(r, a, rst);
            checks++;
            if (bus.gnt !== exp_gnt) begin
                errors++; $display("FAIL rand_gnt[%0d]: got %b expected %b", n, bus.gnt, exp_gnt);
            end
            checks++;
            if (bus.rsp_valid !== exp_rv) begin
                errors++; $display("FAIL rand_rsp_valid[%0d]: got %b expected %b", n, bus.rsp_valid, exp_rv);
            end
            if (exp_rv != 4'b0000) begin
                checks++;
                if (bus.rsp_data !== exp_rd) begin
                    errors++; $display("FAIL rand_rsp_data[%0d]: got %h expected %h", n, bus.rsp_data, exp_rd);
                end
            end
            checks++;
            if (rom_addr !== exp_rom) begin
                errors++; $display("FAIL rand_rom_addr[%0d]: got %h expected %h", n, rom_addr, exp_rom);
            end
            checks++;
            if (conflict_cnt !== exp_cnt) begin
                errors++; $display("FAIL rand_cnt[%0d]: got %h expected %h", n, conflict_cnt, exp_cnt);
            end
            tock();
            // Requesters hold req/address until granted, occasionally abandoning.
            for (int i = 0; i < N; i++) begin
                if (r[i] && exp_win == i) begin
                    r[i] = $urandom_range(0, 1);
                    a[i*20 +: 20] = 20'($urandom);
                end else if (r[i]) begin
                    if ($urandom_range(0, 15) == 0) r[i] = 1'b0;
                end else if ($urandom_range(0, 9) < 4) begin
                    r[i] = 1'b1;
                    a[i*20 +: 20] = 20'($urandom);
                end
            end
        end
    endtask

`ifdef FOOD_ROM_ARB_CONFLICT_CNT_EN
    task automatic test_saturation();
        tick(4'b0000, '0, 1'b1);
        tock();
        for (int n = 0; n < 65540; n++) begin
            tick(4'b1111, pack(0, 1, 2, 3), 1'b0);
            tock();
        end
        tick(4'b1111, pack(0, 1, 2, 3), 1'b0);
        checks++;
        if (conflict_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_cnt: got %h expected FFFF", conflict_cnt);
        end
        tock();
        for (int n = 0; n < 5; n++) begin
            tick(4'b1111, pack(0, 1, 2, 3), 1'b0);
            tock();
        end
        tick(4'b0000, '0, 1'b0);
        checks++;
        if (conflict_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold: got %h expected FFFF", conflict_cnt);
        end
        tock();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_contention();
        test_back_to_back();
        test_reset_midflight();
        test_random();
`ifdef FOOD_ROM_ARB_CONFLICT_CNT_EN
        test_saturation();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
